bch_stream_encoder: RTL and testbench

- Parametrised systematic binary BCH encoder; successor to the fixed (63,51) bch_encoder.
- Accepts a K-bit message serially, MSB first (highest-degree coefficient first), over a valid/ready handshake.
- Emits the N-bit codeword serially over a valid/ready handshake with backpressure: K message bits pass through, then N-K parity bits.
- Sits between the framer and the modulator mapper in the transmit chain.

---
 rtl/bch_stream_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_bch_stream_encoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_stream_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bch_stream_encoder
//
// Parametrised systematic binary BCH encoder with serial streaming I/O.
// A K-bit message arrives MSB first on a valid/ready handshake and is passed
// straight through to a single-register output stage. The N-K parity bits
// follow. The parity bits are the remainder of m(x)*x^(N-K) mod g(x), computed
// by a Galois LFSR.
//
// Parameters:
//   N        codeword length in bits (N > K)
//   K        message length in bits (K >= 1)
//   GEN_POLY generator polynomial g(x), N-K+1 bits, bit N-K set
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   abort      synchronous clear of the codeword in progress (active high)
//   in_valid   message bit valid
//   in_ready   encoder can accept a message bit (combinational)
//   in_data    message bit
//   out_valid  codeword bit valid
//   out_ready  downstream accepts the codeword bit
//   out_data   codeword bit
//   out_last   high with the N-th codeword bit
//   codeword   full codeword           (only with BCH_CW_BUS_EN)
//   cw_valid   one-cycle codeword strobe (only with BCH_CW_BUS_EN)
//
// Optional feature macro: BCH_CW_BUS_EN adds a capture register that
// assembles the serial stream and presents it as a parallel codeword.
// -----------------------------------------------------------------------------
module bch_stream_encoder #(
  parameter int             N        = 63,
  parameter int             K        = 51,
  parameter logic [N-K:0]   GEN_POLY = 13'h1539
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_data,
  output logic         out_last
`ifdef BCH_CW_BUS_EN
  ,
  output logic [N-1:0] codeword,
  output logic         cw_valid
`endif
);

  localparam int R  = N - K;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] MSG_LAST = CW'(K - 1);
  localparam logic [CW-1:0] PAR_LAST = CW'(R - 1);
  localparam logic [R-1:0]  G_TAPS   = GEN_POLY[R-1:0];

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t        r_state,     w_state_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic [R-1:0]  r_par,       w_par_nxt;
  logic          r_out_data,  w_out_data_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_out_last,  w_out_last_nxt;
  logic          w_slot_free;
  logic          w_accept;
  logic          w_fb;

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == ST_MSG) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case/if tree can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_par_nxt       = r_par;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_fb            = 1'b0;

    // A consumed bit empties the slot unless something new is loaded below.
    if (w_slot_free) begin
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end

    unique case (r_state)
      ST_MSG: begin
        if (w_accept) begin
          w_fb            = in_data ^ r_par[R-1];
          w_par_nxt       = (r_par << 1) ^ (w_fb ? G_TAPS : '0);
          w_out_data_nxt  = in_data;
          w_out_valid_nxt = 1'b1;
          if (r_cnt == MSG_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PAR;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_PAR: begin
        // Parity shifts out of the LFSR top without feedback.
        if (w_slot_free) begin
          w_out_data_nxt  = r_par[R-1];
          w_par_nxt       = r_par << 1;
          w_out_valid_nxt = 1'b1;
          if (r_cnt == PAR_LAST) begin
            w_out_last_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_par_nxt      = '0;
            w_state_nxt    = ST_MSG;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: ;
    endcase

    // abort drops the codeword in progress, including any bit offered now.
    if (abort) begin
      w_par_nxt       = '0;
      w_cnt_nxt       = '0;
      w_state_nxt     = ST_MSG;
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_MSG;
      r_cnt       <= '0;
      r_par       <= '0;
      r_out_data  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_par       <= w_par_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

`ifdef BCH_CW_BUS_EN
  logic [N-1:0] r_cap;
  logic [N-1:0] r_codeword;
  logic         r_cw_valid;
  logic         w_load;
  logic         w_done;

  // A bit is loaded into the output register in exactly these two cases.
  assign w_load = !abort && (((r_state == ST_MSG) && w_accept) ||
                             ((r_state == ST_PAR) && w_slot_free));
  assign w_done = !abort && (r_state == ST_PAR) && w_slot_free &&
                  (r_cnt == PAR_LAST);

  // NOTE: the capture register is plain flops, not a RAM, so it is reset
  // like any other register and needs no separate clear sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap      <= '0;
      r_codeword <= '0;
      r_cw_valid <= 1'b0;
    end else begin
      r_cw_valid <= w_done;
      if (abort) begin
        r_cap <= '0;
      end else if (w_load) begin
        r_cap <= {r_cap[N-2:0], w_out_data_nxt};
      end
      // The last presented codeword survives abort until the next one.
      if (w_done) begin
        r_codeword <= {r_cap[N-2:0], w_out_data_nxt};
      end
    end
  end

  assign codeword = r_codeword;
  assign cw_valid = r_cw_valid;
`endif

endmodule

// File: tb/tb_bch_stream_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bch_stream_encoder
//
// Self-checking bench. Expected codewords come from polynomial long division
// over GF(2) on whole bit vectors; a scoreboard queue holds the expected serial
// stream and one compare process checks every transferred output bit and the
// output hold behaviour under backpressure. A second instance exercises the
// N=15, K=7, g=0x1D1 configuration. With BCH_CW_BUS_EN defined the parallel
// codeword port is checked as well.
// -----------------------------------------------------------------------------
module tb_bch_stream_encoder;

  localparam int            N   = 63;
  localparam int            K   = 51;
  localparam int            R   = N - K;
  localparam logic [12:0]   G   = 13'h1539;
  localparam int            N2  = 15;
  localparam int            K2  = 7;
  localparam logic [8:0]    G2  = 9'h1D1;

  logic clk = 1'b0;
  logic rst, abort;
  logic in_valid, in_data, in_ready;
  logic out_valid, out_ready, out_data, out_last;
  logic in_valid2, in_data2, in_ready2;
  logic out_valid2, out_data2, out_last2;
  logic abort2    = 1'b0;
  logic out_ready2 = 1'b1;
`ifdef BCH_CW_BUS_EN
  logic [N-1:0]  codeword;
  logic          cw_valid;
  logic [N2-1:0] codeword2;
  logic          cw_valid2;
`endif

  always #5 clk = ~clk;

  bch_stream_encoder #(.N(N), .K(K), .GEN_POLY(G)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
`ifdef BCH_CW_BUS_EN
    , .codeword(codeword), .cw_valid(cw_valid)
`endif
  );

  bch_stream_encoder #(.N(N2), .K(K2), .GEN_POLY(G2)) dut2 (
    .clk(clk), .rst(rst), .abort(abort2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2)
`ifdef BCH_CW_BUS_EN
    , .codeword(codeword2), .cw_valid(cw_valid2)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=missing expected=present", name);
  endtask

  // ---------------- reference model: GF(2) long division ----------------
  function automatic logic [62:0] poly_mod(input logic [62:0] a, input int n,
                                           input int r, input logic [62:0] g);
    for (int i = n - 1; i >= r; i--)
      if (a[i]) a = a ^ (g << (i - r));
    return a;
  endfunction

  function automatic logic [62:0] encode(input logic [62:0] msg, input int n,
                                         input int k, input logic [62:0] g);
    logic [62:0] sh;
    sh = msg << (n - k);
    return sh | poly_mod(sh, n, n - k, g);
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {logic d; logic l;} ob_t;
  ob_t         exp_q[$];
  logic [62:0] cw_q[$];
  ob_t         got2_q[$];

  task automatic push_cw(input logic [62:0] msg);
    logic [62:0] cw;
    cw = encode(msg, N, K, G);
    for (int i = N - 1; i >= 0; i--) exp_q.push_back({cw[i], i == 0});
    cw_q.push_back(cw);
  endtask

  logic stalled = 1'b0;
  logic held_d, held_l;
  int   ready_low = 0;
  ob_t  e;

  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (!in_ready) ready_low++;
      if (stalled) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_d);
        check("hold_last", out_last, held_l);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_bit");
        else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
      end
`ifdef BCH_CW_BUS_EN
      if (cw_valid) begin
        if (cw_q.size() == 0) fail("unexpected_cw_valid");
        else check("codeword", codeword, cw_q.pop_front());
      end
`endif
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      if (out_valid2 && out_ready2) got2_q.push_back({out_data2, out_last2});
    end
  end

  // ---------------- stimulus ----------------
  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Called at posedge+1; returns at posedge+1 after the bit was accepted.
  task automatic send_bit(input logic b, input bit gaps, input bit sel);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if (sel) begin in_valid2 = 1'b1; in_data2 = b; end
    else     begin in_valid  = 1'b1; in_data  = b; end
    t = 0;
    forever begin
      @(negedge clk);
      if (sel ? in_ready2 : in_ready) break;
      t++;
      if (t > 500) begin fail("in_ready_timeout"); break; end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic send_msg(input logic [62:0] msg, input bit gaps);
    push_cw(msg);
    for (int i = K - 1; i >= 0; i--) send_bit(msg[i], gaps, 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) fail("drain_timeout");
    repeat (2) begin @(posedge clk); #1; end
  endtask

  logic [62:0] msg_a, msg_b, cw;
  logic [62:0] mask;
  logic [6:0]  m2 [4];

  initial begin
    rst = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = 1'b0;
    in_valid2 = 1'b0; in_data2 = 1'b0;
    out_ready = 1'b1;
    mask = (63'd1 << K) - 63'd1;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef BCH_CW_BUS_EN
    check("rst_codeword", codeword, '0);
    check("rst_cw_valid", cw_valid, 1'b0);
`endif

    // Hand-computed pins for the model.
    check("pin_zero", encode(63'd0, N, K, G), 63'd0);
    check("pin_single1", encode(63'd1, N, K, G), 63'h1539);
    check("pin_n15_single1", encode(63'd1, N2, K2, G2), 63'h1D1);
    check("pin_n15_remainder", encode(63'h40, N2, K2, G2) & 63'hFF,
          poly_mod(63'h4000, N2, 8, G2));

    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    // All-zero message alone to measure the in_ready low window.
    ready_low = 0;
    send_msg(63'd0, 1'b0);
    drain();
    check("ready_low_cycles", ready_low, 12);

    // Single 1, then the test-plan message and its linear partner,
    // back to back with no idle cycles.
    msg_a = 63'b010110101101001111001110100100000010101111010001100;
    cw = encode(msg_a, N, K, G);
    check("sys_msg_bits", cw[62:12], msg_a[50:0]);
    check("divisible", poly_mod(cw, N, R, G), 63'd0);
    check("linear", encode(msg_a ^ 63'd1, N, K, G),
          cw ^ encode(63'd1, N, K, G) ^ encode(63'd0, N, K, G));
    send_msg(63'd1, 1'b0);
    send_msg(msg_a, 1'b0);
    send_msg(msg_a ^ 63'd1, 1'b0);
    drain();

    // Random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      msg_b = {$urandom, $urandom};
      send_msg(msg_b & mask, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Abort after 20 message bits, with a bit offered in the abort cycle.
    msg_b = ({$urandom, $urandom}) & mask;
    push_cw(msg_b);
    for (int i = K - 1; i >= K - 20; i--) send_bit(msg_b[i], 1'b0, 1'b0);
    in_valid = 1'b1; in_data = msg_b[K - 21]; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    cw_q.delete();
    @(negedge clk);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send_msg(msg_a, 1'b0);
    drain();

    // Asynchronous reset in the middle of the parity phase.
    send_msg(msg_b, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_last", out_last, 1'b0);
    check("arst_out_data", out_data, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    cw_q.delete();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    send_msg(msg_b ^ 63'h5, 1'b0);
    drain();

    // N=15, K=7 instance: four codewords back to back.
    m2[0] = 7'h01; m2[1] = 7'h5A; m2[2] = 7'h7F; m2[3] = 7'h00;
    for (int m = 0; m < 4; m++)
      for (int i = K2 - 1; i >= 0; i--) send_bit(m2[m][i], 1'b0, 1'b1);
    repeat (20) begin @(posedge clk); #1; end
    check("n15_bit_count", got2_q.size(), 4 * N2);
    if (got2_q.size() == 4 * N2) begin
      for (int m = 0; m < 4; m++) begin
        cw = encode({56'd0, m2[m]}, N2, K2, G2);
        for (int i = N2 - 1; i >= 0; i--) begin
          e = got2_q.pop_front();
          check("n15_data", e.d, cw[i]);
          check("n15_last", e.l, i == 0);
        end
      end
    end

    check("leftover_bits", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
